// File: rtl/uart_pkg.sv
// Shared types and defaults for the 8N1 serial link.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } state_t;

   localparam int unsigned CLKS_PER_BIT_DEF = 16;
   localparam int unsigned DATA_BITS_DEF    = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous level; idles (and resets) high.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic s1;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b1;
         q  <= 1'b1;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 frame receiver: finds the start bit, samples each bit at its centre and
// strobes either the recovered word or a framing error.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int unsigned DATA_BITS    = DATA_BITS_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_in,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

   logic                 rx_s;
   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 err_q, err_d;

   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx_in),
      .q   (rx_s)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      err_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rx_s) state_d = START;
         end
         START: begin
            // Half a bit in: a line that is high again was only a glitch.
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
               idx_d   = idx_q + IDX_W'(1);
               if (idx_q == IDX_LAST) state_d = STOP;
            end
         end
         STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  err_d   = 1'b1;
                  state_d = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            // Hold off until the line recovers so a break never looks like a start.
            cnt_d = '0;
            if (rx_s) state_d = IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign data_out   = data_q;
   assign data_valid = valid_q;
   assign frame_err  = err_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame table, timed corner sequences and random frames
// scored against a frame-level model of the receiver.
module tb_uart_rx;

   localparam int CPB = 16;
   localparam int DB  = 8;
   // Cycle count from the driving point to the strobe cycle (edge 154 + 1).
   localparam int STROBE_LAT = 2 + CPB / 2 + (DB + 1) * CPB + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          rx_in = 1'b1;
   logic [DB-1:0] data_out;
   logic          data_valid;
   logic          frame_err;
   logic          busy;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct {
      int          cyc;
      logic        v;
      logic        e;
      logic [DB-1:0] d;
   } ev_t;

   typedef struct {
      logic [DB-1:0] d;
      bit            stop_ok;
      int            extra_low;
      int            gap;
      logic          exp_v;
      logic [DB-1:0] exp_d;
   } vec_t;

   ev_t obs[$];

   uart_rx #(
      .CLKS_PER_BIT (CPB),
      .DATA_BITS    (DB)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_in      (rx_in),
      .data_out   (data_out),
      .data_valid (data_valid),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (data_valid || frame_err) obs.push_back('{cyc, data_valid, frame_err, data_out});
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Call just after a rising edge; the next edge is edge 0 of the frame.
   task automatic send_frame(input logic [DB-1:0] d, input bit stop_ok, input int extra_low,
                             input int gap, output int strobe_cyc);
      strobe_cyc = cyc + STROBE_LAT;
      rx_in = 1'b0;
      repeat (CPB) @(posedge clk);
      #1;
      for (int i = 0; i < DB; i++) begin
         rx_in = d[i];
         repeat (CPB) @(posedge clk);
         #1;
      end
      rx_in = stop_ok;
      repeat (CPB * (stop_ok ? 1 : 1 + extra_low)) @(posedge clk);
      #1;
      rx_in = 1'b1;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_one(input string name, input int ecyc, input logic ev,
                             input logic [DB-1:0] ed);
      ev_t o;
      check({name, " strobe count"}, 64'(obs.size()), 64'(1));
      if (obs.size() > 0) begin
         o = obs.pop_front();
         check({name, " strobe cycle"}, 64'(o.cyc), 64'(ecyc));
         check({name, " data_valid"}, 64'(o.v), 64'(ev));
         check({name, " frame_err"}, 64'(o.e), 64'(!ev));
         check({name, " data_out"}, 64'(o.d), 64'(ed));
      end
      obs.delete();
   endtask

   initial begin
      vec_t          vecs[4];
      int            sc;
      logic [DB-1:0] last_good;
      logic [DB-1:0] rd;
      bit            rok;
      int            rextra;
      int            rgap;

      vecs[0] = '{8'h00, 1'b1, 0, 0, 1'b1, 8'h00};
      vecs[1] = '{8'hFF, 1'b1, 0, 6, 1'b1, 8'hFF};
      vecs[2] = '{8'h3C, 1'b0, 3, 6, 1'b0, 8'hFF};
      vecs[3] = '{8'h5A, 1'b1, 0, 6, 1'b1, 8'h5A};

      // Reset with the line idle.
      repeat (5) @(posedge clk);
      #1;
      check("reset data_out", 64'(data_out), 64'(0));
      check("reset data_valid", 64'(data_valid), 64'(0));
      check("reset frame_err", 64'(frame_err), 64'(0));
      check("reset busy", 64'(busy), 64'(0));
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      obs.delete();

      // Single frame with busy edges checked around start and strobe.
      fork
         send_frame(8'hA5, 1'b1, 0, 4, sc);
         begin
            repeat (2) @(posedge clk);
            @(negedge clk);
            check("busy after edge1", 64'(busy), 64'(0));
            @(posedge clk);
            @(negedge clk);
            check("busy after edge2", 64'(busy), 64'(1));
            repeat (151) @(posedge clk);
            @(negedge clk);
            check("busy after edge153", 64'(busy), 64'(1));
            @(posedge clk);
            @(negedge clk);
            check("busy after edge154", 64'(busy), 64'(0));
         end
      join
      expect_one("frame A5", sc, 1'b1, 8'hA5);

      // Table: back-to-back 00/FF, bad stop on 3C, then a clean 5A.
      for (int i = 0; i < 4; i++) begin
         send_frame(vecs[i].d, vecs[i].stop_ok, vecs[i].extra_low, vecs[i].gap, sc);
         expect_one($sformatf("vec%0d", i), sc, vecs[i].exp_v, vecs[i].exp_d);
         check($sformatf("vec%0d data_out hold", i), 64'(data_out), 64'(vecs[i].exp_d));
      end
      last_good = 8'h5A;

      // Break after a bad stop bit: busy until the line comes back high.
      fork
         send_frame(8'h3C, 1'b0, 3, 4, sc);
         begin
            repeat (201) @(posedge clk);
            @(negedge clk);
            check("busy during break", 64'(busy), 64'(1));
            repeat (10) @(posedge clk);
            @(negedge clk);
            check("busy after break", 64'(busy), 64'(0));
         end
      join
      expect_one("break 3C", sc, 1'b0, last_good);
      send_frame(8'hC3, 1'b1, 0, 4, sc);
      expect_one("after break C3", sc, 1'b1, 8'hC3);
      last_good = 8'hC3;

      // Four-cycle glitch on an idle line.
      rx_in = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rx_in = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("glitch busy edge9", 64'(busy), 64'(1));
      @(posedge clk);
      @(negedge clk);
      check("glitch busy edge10", 64'(busy), 64'(0));
      repeat (20) @(posedge clk);
      #1;
      check("glitch no strobe", 64'(obs.size()), 64'(0));
      obs.delete();

      // Reset at edge 60 of a frame.
      fork
         send_frame(8'hFF, 1'b1, 0, 40, sc);
         begin
            repeat (60) @(posedge clk);
            #1;
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            @(negedge clk);
            check("midreset data_out", 64'(data_out), 64'(0));
            check("midreset data_valid", 64'(data_valid), 64'(0));
            check("midreset frame_err", 64'(frame_err), 64'(0));
            check("midreset busy", 64'(busy), 64'(0));
         end
      join
      check("aborted frame silent", 64'(obs.size()), 64'(0));
      obs.delete();
      send_frame(8'h81, 1'b1, 0, 4, sc);
      expect_one("post-reset 81", sc, 1'b1, 8'h81);
      last_good = 8'h81;

      // Random frames scored against the frame-level model.
      for (int n = 0; n < 24; n++) begin
         rd     = DB'($urandom);
         rok    = ($urandom_range(0, 4) != 0);
         rextra = rok ? 0 : int'($urandom_range(0, 2));
         rgap   = rok ? int'($urandom_range(0, 12)) : int'($urandom_range(2, 12));
         send_frame(rd, rok, rextra, rgap, sc);
         if (rok) last_good = rd;
         expect_one($sformatf("rand%0d", n), sc, rok, last_good);
      end
      check("final data_out", 64'(data_out), 64'(last_good));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel frame receiver: the receive end of the team's 8N1 serial link, whose transmit end is a shift register of D flip-flops. It synchronises the asynchronous line and locates each frame's start bit. It samples each bit at its centre and presents the recovered word with a one-cycle valid strobe, or a framing-error strobe. It sits between the pin-level serial input and the parallel consumer logic.

## Interface
- CLKS_PER_BIT, 16: clock cycles per serial bit; even, ≥4.
- DATA_BITS, 8: payload bits per frame, sent LSB first; legal range 5..9.
- clk  in  1  single system clock; all logic acts on its rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_in  in  1  asynchronous serial line; idles high.
- data_out  out  DATA_BITS  last correctly received word; holds until the next good frame.
- data_valid  out  1  one-cycle pulse when data_out is updated.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- Two-flop synchroniser: s1 <= rx_in; s2 <= s1. Both flops reset to 1. All decisions use s2 only.
- Bit counter cnt has width $clog2(CLKS_PER_BIT). Index counter idx has width $clog2(DATA_BITS+1).
- Reset values: data_out=0, data_valid=0, frame_err=0, busy=0, state=IDLE, cnt=0, idx=0, shift register=0.
- IDLE: when s2==0, go to START and set cnt=0.
- START: increment cnt. When cnt==CLKS_PER_BIT/2-1, sample s2:
  - s2==0: go to DATA and set cnt=0, idx=0.
  - s2==1 (glitch): return to IDLE. No strobe.
- DATA: increment cnt. When cnt==CLKS_PER_BIT-1:
  - shift s2 into the MSB of the shift register (right shift, so the first bit ends at the LSB); set cnt=0; increment idx.
  - After DATA_BITS samples, go to STOP.
- STOP: when cnt==CLKS_PER_BIT-1, sample s2:
  - s2==1: data_out<=shift, data_valid=1 for one cycle, go to IDLE.
  - s2==0: frame_err=1 for one cycle, data_out unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until s2==1, then go to IDLE. A held-low line (break) therefore never re-triggers a start.
- data_valid and frame_err are never high in the same cycle.
- Reset mid-frame: the next cycle shows reset values. A partial word is discarded and nothing is strobed. Low data bits left in the aborted frame may be taken as a new start; that frame then fails the stop check or the glitch check.

## Timing
- Edge 0 is the first rising edge at which rx_in is sampled low.
- s2 goes low after edge 1. START is entered at edge 2.
- Start-bit check at edge 2+CLKS_PER_BIT/2. Data bit i (i=1..DATA_BITS) is sampled at edge 2+CLKS_PER_BIT/2+i·CLKS_PER_BIT.
- data_valid or frame_err is high in the cycle after edge 2+CLKS_PER_BIT/2+(DATA_BITS+1)·CLKS_PER_BIT. With the defaults this is edge 154.
- The stop bit is sampled at its centre, so IDLE is re-entered half a bit early. A start bit beginning at the nominal stop-bit end is caught with no lost cycles.
- busy is high from edge 2 through the strobe edge, and also throughout WAIT_HIGH.

## Structure
- Package uart_pkg holds:
  - the state enum: IDLE, START, DATA, STOP, WAIT_HIGH;
  - default constants CLKS_PER_BIT_DEF=16 and DATA_BITS_DEF=8.
- Sub-module sync_2ff is the two-flop synchroniser, with clk, rst, d and q; reset value 1. It is reusable by the future transmitter's handshake inputs.
- Everything else lives in one FSM with counters in uart_rx.

## Test plan
- Reset with rx_in=1 held for 5 cycles → data_out=0, data_valid=0, frame_err=0, busy=0.
- Frame 0xA5 at the defaults → exactly one data_valid pulse, in the cycle after edge 154; data_out=0xA5.
- Back-to-back frames 0x00 then 0xFF, no idle gap → two data_valid pulses 160 cycles apart, values 0x00 then 0xFF.
- Line low for 4 cycles, then high → no strobe; busy drops after edge 10.
- Frame 0x3C with the stop bit low, line held low 3 more bit times → frame_err pulse at edge 154; data_out keeps its previous value; busy stays high until the line returns high; the next clean frame 0x5A is received correctly.
- rst pulsed at edge 60 of a frame → reset values the next cycle; after the line idles high, a clean frame 0x81 gives data_out=0x81.
